// File: rtl/poly1305_mulacc_n.sv
// poly1305_mulacc_n: sequential multiply-accumulate, one product per cycle.
// sum = sum0 + SUM(opa[i]*opb[i]) over NUM_TERMS terms, with a sticky overflow
// flag and a chained-accumulate mode (acc=1) for multi-pass reductions.
module poly1305_mulacc_n #(
    parameter int NUM_TERMS = 5,
    parameter int OPA_WIDTH = 32,
    parameter int OPB_WIDTH = 64,
    parameter int SUM_WIDTH = 64
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic                           acc,
    input  logic [NUM_TERMS*OPA_WIDTH-1:0] opa,
    input  logic [NUM_TERMS*OPB_WIDTH-1:0] opb,
    output logic                           ready,
    output logic [SUM_WIDTH-1:0]           sum,
    output logic                           overflow
);

    // Full product width, and a working width large enough for both the
    // untruncated product and the sum so the drop test needs no special case.
    localparam int PW = OPA_WIDTH + OPB_WIDTH;
    localparam int XW = (PW > SUM_WIDTH) ? PW : SUM_WIDTH;
    // idx runs 1..NUM_TERMS, so it needs room for NUM_TERMS itself.
    localparam int IW = $clog2(NUM_TERMS + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TERM = 2'd1,
        ST_SUM  = 2'd2
    } state_t;

    state_t               state_q;
    logic [IW-1:0]        idx_q;
    logic [SUM_WIDTH-1:0] mul_q;
    logic [SUM_WIDTH-1:0] sum_q;
    logic                 ovf_q;
    logic                 ready_q;

    logic [IW-1:0]        idx_sel;
    logic [OPA_WIDTH-1:0] opa_sel;
    logic [OPB_WIDTH-1:0] opb_sel;
    logic [XW-1:0]        prod_full;
    logic [SUM_WIDTH-1:0] mul_d;
    logic                 prod_drop;
    logic [SUM_WIDTH:0]   add_full;
    logic [SUM_WIDTH-1:0] sum_d;
    logic                 add_carry;

    // Term selection: the start cycle always uses term 0, later cycles use idx.
    // Operands are not latched; the caller holds them stable for the operation.
    always_comb begin
        idx_sel = (state_q == ST_IDLE) ? '0 : idx_q;
        opa_sel = '0;
        opb_sel = '0;
        for (int i = 0; i < NUM_TERMS; i++) begin
            if (int'(idx_sel) == i) begin
                opa_sel = opa[i*OPA_WIDTH +: OPA_WIDTH];
                opb_sel = opb[i*OPB_WIDTH +: OPB_WIDTH];
            end
        end
    end

    // Single shared multiplier; result truncated to SUM_WIDTH bits.
    assign prod_full = XW'(opa_sel) * XW'(opb_sel);
    assign mul_d     = prod_full[SUM_WIDTH-1:0];

    generate
        if (XW > SUM_WIDTH) begin : g_drop
            assign prod_drop = |prod_full[XW-1:SUM_WIDTH];
        end else begin : g_nodrop
            assign prod_drop = 1'b0;
        end
    endgenerate

    // Accumulator adder; the carry out is reported through overflow.
    assign add_full  = {1'b0, sum_q} + {1'b0, mul_q};
    assign sum_d     = add_full[SUM_WIDTH-1:0];
    assign add_carry = add_full[SUM_WIDTH];

    // Control FSM and datapath registers: IDLE -> TERM* -> SUM -> IDLE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            mul_q   <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mul_q   <= mul_d;
                        ready_q <= 1'b0;
                        idx_q   <= IW'(1);
                        if (acc) begin
                            ovf_q <= ovf_q | prod_drop;
                        end else begin
                            sum_q <= '0;
                            ovf_q <= prod_drop;
                        end
                        state_q <= (NUM_TERMS > 1) ? ST_TERM : ST_SUM;
                    end
                end
                ST_TERM: begin
                    sum_q <= sum_d;
                    mul_q <= mul_d;
                    ovf_q <= ovf_q | add_carry | prod_drop;
                    idx_q <= idx_q + IW'(1);
                    if (idx_q == IW'(NUM_TERMS - 1)) begin
                        state_q <= ST_SUM;
                    end
                end
                ST_SUM: begin
                    sum_q   <= sum_d;
                    ovf_q   <= ovf_q | add_carry;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready    = ready_q;
    assign sum      = sum_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_poly1305_mulacc_n.sv
// Testbench for poly1305_mulacc_n: spec vectors from a table, hand-written
// corner sequences, and randomized operations against a plain-arithmetic model.
module tb_poly1305_mulacc_n;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         acc = 1'b0;
    logic [159:0] opa = '0;
    logic [319:0] opb = '0;
    logic         ready;
    logic [63:0]  sum;
    logic         overflow;

    logic         start1 = 1'b0;
    logic         acc1 = 1'b0;
    logic [31:0]  opa1 = '0;
    logic [63:0]  opb1 = '0;
    logic         ready1;
    logic [31:0]  sum1;
    logic         overflow1;

    int checks = 0;
    int failures = 0;

    logic [63:0] m_sum;
    bit          m_ovf;

    always #5 clk = ~clk;

    poly1305_mulacc_n dut (
        .clk(clk), .reset_n(reset_n), .start(start), .acc(acc),
        .opa(opa), .opb(opb), .ready(ready), .sum(sum), .overflow(overflow)
    );

    poly1305_mulacc_n #(.NUM_TERMS(1), .SUM_WIDTH(32)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .acc(acc1),
        .opa(opa1), .opb(opb1), .ready(ready1), .sum(sum1), .overflow(overflow1)
    );

    typedef struct {
        string        name;
        bit           acc;
        logic [159:0] a;
        logic [319:0] b;
        logic [63:0]  exp_sum;
        bit           exp_ovf;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    // Reference: sum of products with each product truncated to 64 bits and
    // every 64-bit addition wrapping; any lost bit sets the sticky flag.
    function automatic void ref_op(input bit acc_in, input logic [159:0] a, input logic [319:0] b);
        logic [127:0] p;
        logic [64:0]  s;
        if (!acc_in) begin
            m_sum = '0;
            m_ovf = 1'b0;
        end
        for (int i = 0; i < 5; i++) begin
            p = 128'(a[i*32 +: 32]) * 128'(b[i*64 +: 64]);
            if (p[127:64] != 64'd0) m_ovf = 1'b1;
            s = {1'b0, m_sum} + {1'b0, p[63:0]};
            if (s[64]) m_ovf = 1'b1;
            m_sum = s[63:0];
        end
    endfunction

    // Start one operation on the default instance (called #1 after an edge);
    // glitch_at>0 re-pulses start so it is sampled that many edges after the
    // accepted start. Returns the cycle (start cycle = 0) in which ready is seen.
    task automatic run_op(input bit a_acc, input logic [159:0] a, input logic [319:0] b,
                          input int glitch_at, output int lat);
        acc = a_acc; opa = a; opb = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            if (ready) begin
                lat = c;
                break;
            end
            start = (c == glitch_at);
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic run_small(input bit a_acc, input logic [31:0] a, input logic [63:0] b, output int lat);
        acc1 = a_acc; opa1 = a; opb1 = b; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            if (ready1) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    logic [159:0] spec_a;
    logic [319:0] spec_b;
    logic [159:0] ov_a;
    logic [319:0] ov_b;
    vec_t         tbl[4];
    int           lat;

    initial begin
        for (int i = 0; i < 5; i++) begin
            spec_a[i*32 +: 32] = 32'(i + 1);
            spec_b[i*64 +: 64] = 64'(10 * (i + 1));
        end
        ov_a = '0;
        ov_b = '0;
        ov_a[31:0] = 32'hFFFF_FFFF;
        ov_b[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;

        tbl[0] = '{"basic",      1'b0, spec_a, spec_b, 64'h226, 1'b0};
        tbl[1] = '{"chain",      1'b1, spec_a, spec_b, 64'h44C, 1'b0};
        tbl[2] = '{"prod_ovf",   1'b0, ov_a,   ov_b,   64'hFFFF_FFFF_0000_0001, 1'b1};
        tbl[3] = '{"ovf_clear",  1'b0, spec_a, spec_b, 64'h226, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_sum", sum, 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_ready1", 64'(ready1), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Spec vectors, back-to-back (each start issued right after ready)
        foreach (tbl[k]) begin
            run_op(tbl[k].acc, tbl[k].a, tbl[k].b, 0, lat);
            chk({tbl[k].name, "_lat"}, 64'(lat), 64'd6);
            chk({tbl[k].name, "_sum"}, sum, tbl[k].exp_sum);
            chk({tbl[k].name, "_ovf"}, 64'(overflow), 64'(tbl[k].exp_ovf));
        end

        // start pulsed 2 cycles into an operation must be ignored
        run_op(1'b0, spec_a, spec_b, 2, lat);
        chk("ign_lat", 64'(lat), 64'd6);
        chk("ign_sum", sum, 64'h226);
        repeat (4) @(posedge clk);
        #1;
        chk("ign_hold_ready", 64'(ready), 64'd1);
        chk("ign_hold_sum", sum, 64'h226);

        // Reset during the 3rd TERM cycle aborts the operation
        run_op(1'b0, ov_a, ov_b, 0, lat);
        chk("pre_abort_ovf", 64'(overflow), 64'd1);
        acc = 1'b1; opa = spec_a; opb = spec_b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_ready", 64'(ready), 64'd0);
        chk("abort_sum", sum, 64'd0);
        chk("abort_ovf", 64'(overflow), 64'd0);
        reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_result", 64'(ready), 64'd0);
        run_op(1'b0, spec_a, spec_b, 0, lat);
        chk("post_abort_lat", 64'(lat), 64'd6);
        chk("post_abort_sum", sum, 64'h226);

        // Randomized operations, first one clears so the model starts in sync
        for (int n = 0; n < 40; n++) begin
            logic [159:0] ra;
            logic [319:0] rb;
            bit           racc;
            for (int i = 0; i < 5; i++) begin
                ra[i*32 +: 32] = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 255));
                rb[i*64 +: 64] = ($urandom_range(0, 1) == 1) ? {32'($urandom), 32'($urandom)}
                                                             : 64'($urandom_range(0, 4095));
            end
            racc = (n == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            ref_op(racc, ra, rb);
            run_op(racc, ra, rb, 0, lat);
            chk($sformatf("rnd%0d_lat", n), 64'(lat), 64'd6);
            chk($sformatf("rnd%0d_sum", n), sum, m_sum);
            chk($sformatf("rnd%0d_ovf", n), 64'(overflow), 64'(m_ovf));
        end

        // Single-term instance with a 32-bit sum
        run_small(1'b0, 32'd3, 64'd7, lat);
        chk("nt1_lat", 64'(lat), 64'd2);
        chk("nt1_sum", 64'(sum1), 64'd21);
        chk("nt1_ovf", 64'(overflow1), 64'd0);
        run_small(1'b1, 32'd3, 64'd7, lat);
        chk("nt1_chain_sum", 64'(sum1), 64'd42);
        run_small(1'b0, 32'h0001_0000, 64'h0001_0000, lat);
        chk("nt1_drop_sum", 64'(sum1), 64'd0);
        chk("nt1_drop_ovf", 64'(overflow1), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
